// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encoding and screen colours for the game session controller
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAYING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam logic [23:0] COLOR_IDLE   = 24'h0000FF;
  localparam logic [23:0] COLOR_PAUSED = 24'h808080;
  localparam logic [23:0] COLOR_WIN    = 24'h00FF00;
  localparam logic [23:0] COLOR_LOSE   = 24'hFF0000;

endpackage

// File: rtl/bcd_counter.sv
// rtl/bcd_counter.sv - multi-digit BCD up-counter that saturates at all-9s
// Ports: clk, rst (sync active-low), clr (zero), inc (+1), value (BCD, digit 0 low), at_max (all 9s)
module bcd_counter #(
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    inc,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic                    at_max
);

  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic                    carry;

  always_comb begin
    at_max = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (value_q[4*i +: 4] != 4'd9) at_max = 1'b0;
    end
  end

  // Ripple the carry digit by digit; at all-9s the carry is never injected.
  always_comb begin
    value_d = value_q;
    carry   = inc & ~at_max;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (value_q[4*i +: 4] == 4'd9) begin
          value_d[4*i +: 4] = 4'd0;
        end else begin
          value_d[4*i +: 4] = value_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    if (clr) value_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) value_q <= '0;
    else      value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/seven_segment.sv
// rtl/seven_segment.sv - BCD digit to active-low seven-segment pattern
// Ports: digit (BCD in), seg (gfedcba, active-low; non-BCD codes blank)
module seven_segment (
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/game_session_ctrl.sv
// rtl/game_session_ctrl.sv - game session FSM with BCD score/timer, seven-segment display and screen colour
// Ports: clk, rst (sync active-low); start (level), pause_p/reveal_p (pulses), endgame/win, disp_sel,
//        game_color in; screen_color (registered), game_run, state, hex (active-low, digit 0 low) out
module game_session_ctrl
  import game_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int CLK_HZ      = 50_000_000,
  parameter int DONE_HOLD_S = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    pause_p,
  input  logic                    reveal_p,
  input  logic                    endgame,
  input  logic                    win,
  input  logic                    disp_sel,
  input  logic [23:0]             game_color,
  output logic [23:0]             screen_color,
  output logic                    game_run,
  output logic [1:0]              state,
  output logic [7*NUM_DIGITS-1:0] hex
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int HW = (DONE_HOLD_S > 1) ? $clog2(DONE_HOLD_S) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(DONE_HOLD_S - 1);

  state_e                  state_q, state_d;
  logic                    start_q, start_edge;
  logic                    win_q;
  logic [PW-1:0]           presc_q, presc_d;
  logic [HW-1:0]           hold_q, hold_d;
  logic                    tick;
  logic [23:0]             screen_color_q, screen_color_d;
  logic [4*NUM_DIGITS-1:0] score_v, timer_v, disp_v;
  logic                    score_max, timer_max;
  logic                    cnt_clr;
  logic [7*NUM_DIGITS-1:0] seg_raw;
  logic [NUM_DIGITS-1:0]   blank;
  logic                    lead;

  assign start_edge = start & ~start_q;
  assign tick       = ((state_q == ST_PLAYING) || (state_q == ST_DONE)) && (presc_q == PRESC_MAX);
  assign cnt_clr    = (state_q == ST_IDLE) && start_edge;

  // State register and the state-scoped sequential bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      start_q        <= 1'b1;
      win_q          <= 1'b0;
      presc_q        <= '0;
      hold_q         <= '0;
      screen_color_q <= 24'h000000;
    end else begin
      state_q        <= state_d;
      start_q        <= start;
      presc_q        <= presc_d;
      hold_q         <= hold_d;
      screen_color_q <= screen_color_d;
      if ((state_q == ST_PLAYING) && endgame) win_q <= win;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start_edge) state_d = ST_PLAYING;
      ST_PLAYING: begin
        if (endgame)      state_d = ST_DONE;
        else if (pause_p) state_d = ST_PAUSED;
      end
      ST_PAUSED:  if (pause_p) state_d = ST_PLAYING;
      ST_DONE: begin
        if (start_edge || (tick && (hold_q == HOLD_LAST))) state_d = ST_IDLE;
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  // Prescaler and done-hold counter restart on any state change so a
  // partial second never carries across a pause or into DONE.
  always_comb begin
    presc_d = presc_q;
    hold_d  = hold_q;
    if (state_d != state_q) begin
      presc_d = '0;
      hold_d  = '0;
    end else if ((state_q == ST_PLAYING) || (state_q == ST_DONE)) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if ((state_q == ST_DONE) && tick) hold_d = hold_q + 1'b1;
    end
  end

  // Output logic.
  always_comb begin
    game_run = (state_q == ST_PLAYING);
    case (state_q)
      ST_IDLE:    screen_color_d = COLOR_IDLE;
      ST_PLAYING: screen_color_d = game_color;
      ST_PAUSED:  screen_color_d = COLOR_PAUSED;
      ST_DONE:    screen_color_d = win_q ? COLOR_WIN : COLOR_LOSE;
      default:    screen_color_d = COLOR_IDLE;
    endcase
  end

  assign screen_color = screen_color_q;
  assign state        = state_q;

  bcd_counter #(.NUM_DIGITS(NUM_DIGITS)) u_score (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .inc    (reveal_p && (state_q == ST_PLAYING) && !score_max),
    .value  (score_v),
    .at_max (score_max)
  );

  bcd_counter #(.NUM_DIGITS(NUM_DIGITS)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .inc    (tick && (state_q == ST_PLAYING) && !timer_max),
    .value  (timer_v),
    .at_max (timer_max)
  );

  assign disp_v = disp_sel ? timer_v : score_v;

  // A digit is blank while every digit above and including it is zero.
  always_comb begin
    lead  = 1'b1;
    blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (disp_v[4*i +: 4] != 4'd0) lead = 1'b0;
      blank[i] = lead;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    seven_segment u_seg (
      .digit (disp_v[4*g +: 4]),
      .seg   (seg_raw[7*g +: 7])
    );
    assign hex[7*g +: 7] = blank[g] ? 7'h7F : seg_raw[7*g +: 7];
  end

endmodule
